game_phase_ctrl: RTL and testbench
==================================

Name: game_phase_ctrl

Overview:
Central sequencer for the bunny game. It turns raw start and pause button levels and game events into a phased game flow: IDLE, COUNTDOWN, PLAY, PAUSE, GAMEOVER. It owns the 1-second timebase, the countdown, the play timer and the life counter. It drives the gamestart enable that the sprite, score and display blocks consume.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1-second tick (≥2)
COUNTDOWN_S, 3, countdown length in seconds (1..7)
PLAY_TIME_S, 60, play duration in seconds (1..127)
LIVES_INIT, 3, lives at game start (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  start button level, synchronous to clk
pause  in  1  pause button level, synchronous to clk
life_lost  in  1  one-cycle pulse: player lost a life
gamestart  out  1  high only in PLAY; gates gameplay logic
phase  out  3  current phase: 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 GAMEOVER
countdown  out  3  seconds remaining in COUNTDOWN, 0 elsewhere
time_left  out  7  play seconds remaining
lives  out  2  lives remaining
game_over  out  1  high in GAMEOVER
tick_1s  out  1  one-cycle pulse every TICK_DIV cycles while running

Behaviour:
- Reset (rst=0, asynchronous) puts outputs at these values: phase=IDLE, gamestart=0, countdown=0, time_left=PLAY_TIME_S, lives=LIVES_INIT, game_over=0, tick_1s=0. The prescaler and the edge-detect registers clear to 0.
- Edge detect: start_rise = start & ~start_d and pause_rise = pause & ~pause_d, where start_d and pause_d are registered one cycle. Holding a button high never re-triggers.
- Prescaler: counts 0..TICK_DIV-1 only in COUNTDOWN and PLAY. tick_1s pulses for one cycle when the count wraps. In IDLE, PAUSE and GAMEOVER the count holds. The prescaler clears on entry to COUNTDOWN, so the first tick comes exactly TICK_DIV cycles after entry.
- IDLE: on start_rise, go to COUNTDOWN with countdown=COUNTDOWN_S, time_left=PLAY_TIME_S, lives=LIVES_INIT.
- COUNTDOWN: each tick decrements countdown. The tick that would bring it to 0 instead enters PLAY, with countdown=0 and gamestart=1 in the same register update. pause_rise and life_lost are ignored.
- PLAY: each tick decrements time_left. life_lost decrements lives.
  - GAMEOVER is entered on whichever happens first: time_left reaching 0, or lives reaching 0.
  - Tick and life_lost in the same cycle: both decrements apply. If either result is 0, go to GAMEOVER.
  - pause_rise goes to PAUSE. If pause_rise coincides with a tick or life_lost, the decrements apply first. GAMEOVER takes priority over PAUSE.
- PAUSE: gamestart=0; timers and lives are frozen and life_lost is ignored. pause_rise returns to PLAY with the prescaler count preserved. start_rise returns to IDLE (abort), with no counter reload until the next start.
- GAMEOVER: gamestart=0, game_over=1, time_left and lives hold their final values. start_rise goes to IDLE. A start_rise in GAMEOVER does not also start a game; a second press is required.
- Only the IDLE → COUNTDOWN transition responds to start_rise in the same cycle. start is ignored in COUNTDOWN and PLAY.
- Saturation: lives and time_left never wrap below 0. A life_lost at lives=0 cannot occur, because lives=0 means GAMEOVER.
- All outputs are registered, so phase changes are visible one cycle after the triggering event.
- Reset mid-game aborts immediately to the reset values.
- Unused phase encodings 5..7 recover to IDLE on the next clock.

Decomposition:
- Shared package game_pkg:
  - phase encodings PH_IDLE=3'd0 … PH_GAMEOVER=3'd4
  - widths TIME_W=7, LIVES_W=2, CD_W=3
- Sub-module tick_gen:
  - parameter TICK_DIV
  - inputs clk, rst, en, clr
  - output tick (one-cycle pulse)
  - instantiated once for the prescaler.

Test Plan (TICK_DIV=4, COUNTDOWN_S=3, PLAY_TIME_S=5, LIVES_INIT=3):
- Reset then start pulse → phase=1 and countdown=3 on the next edge. countdown steps 3→2→1 every 4 cycles. phase=2 and gamestart=1 exactly 12 cycles after entry. Holding start high causes no restart.
- Uninterrupted play → time_left 5→0 over 20 cycles, then phase=4, game_over=1, gamestart=0, lives=3.
- Three life_lost pulses in PLAY → lives 3→2→1→0. GAMEOVER on the third pulse while time_left>0. time_left holds its value.
- life_lost coincident with the tick at time_left=1, lives=2 → time_left=0, lives=1, phase=4.
- pause_rise in PLAY at time_left=3 → phase=3 for 50 cycles with no tick_1s and time_left=3. pause_rise again → phase=2, and the next tick arrives after the remaining prescaler cycles.
- rst asserted low mid-COUNTDOWN → all outputs return to reset values immediately. start_rise in GAMEOVER → IDLE only; a second start_rise → COUNTDOWN.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the bunny game sequencer.
//   - phase_t : phase encodings driven on game_phase_ctrl.phase
//   - TIME_W, LIVES_W, CD_W : widths of the play timer, life counter and
//     countdown registers
//   - time_dec_sat / lives_dec_sat : conditional decrement that stops at 0
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int TIME_W  = 7;
    localparam int LIVES_W = 2;
    localparam int CD_W    = 3;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_COUNTDOWN = 3'd1,
        PH_PLAY      = 3'd2,
        PH_PAUSE     = 3'd3,
        PH_GAMEOVER  = 3'd4
    } phase_t;

    // Decrement the play timer when dec is set, never wrapping below zero.
    function automatic logic [TIME_W-1:0] time_dec_sat(
        input logic [TIME_W-1:0] value,
        input logic              dec
    );
        if (dec && (value != '0)) begin
            return value - TIME_W'(1);
        end
        return value;
    endfunction

    // Decrement the life counter when dec is set, never wrapping below zero.
    function automatic logic [LIVES_W-1:0] lives_dec_sat(
        input logic [LIVES_W-1:0] value,
        input logic               dec
    );
        if (dec && (value != '0)) begin
            return value - LIVES_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/game_phase_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle pulse every TICK_DIV enabled clocks.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset, clears the count
//   en   : count advances only while high; otherwise the count holds
//   clr  : synchronous clear of the count (wins over en)
//   tick : high during the cycle in which the count is about to wrap, so a
//          consumer sampling it on the next edge sees exactly one pulse per
//          TICK_DIV enabled cycles
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // The tick is combinational so the sequencer can act on it in the very
    // edge where the count wraps; the first tick after a clear therefore
    // lands exactly TICK_DIV enabled edges later.
    assign tick = en && !clr && (count == LAST);

    // Count 0..TICK_DIV-1 while enabled, hold while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// ---------------------------------------------------------------------------
// game_phase_ctrl
// Central sequencer of the bunny game: IDLE -> COUNTDOWN -> PLAY <-> PAUSE,
// ending in GAMEOVER. Owns the 1-second timebase, countdown, play timer and
// life counter. All outputs come straight from flops.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   start     : start button level (synchronous to clk)
//   pause     : pause button level (synchronous to clk)
//   life_lost : one-cycle pulse, player lost a life
//   gamestart : high only in PLAY, gates the gameplay blocks
//   phase     : 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 GAMEOVER
//   countdown : seconds remaining in COUNTDOWN, 0 elsewhere
//   time_left : play seconds remaining
//   lives     : lives remaining
//   game_over : high in GAMEOVER
//   tick_1s   : one-cycle pulse per elapsed second while running
// ---------------------------------------------------------------------------
module game_phase_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int COUNTDOWN_S = 3,
    parameter int PLAY_TIME_S = 60,
    parameter int LIVES_INIT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               life_lost,
    output logic               gamestart,
    output logic [2:0]         phase,
    output logic [CD_W-1:0]    countdown,
    output logic [TIME_W-1:0]  time_left,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic               tick_1s
);

    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(COUNTDOWN_S);
    localparam logic [TIME_W-1:0]  TIME_LOAD  = TIME_W'(PLAY_TIME_S);
    localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

    phase_t state;

    logic start_d;
    logic pause_d;
    logic start_rise;
    logic pause_rise;

    logic tick;
    logic tick_en;
    logic tick_clr;

    logic [TIME_W-1:0]  time_next;
    logic [LIVES_W-1:0] lives_next;

    assign start_rise = start & ~start_d;
    assign pause_rise = pause & ~pause_d;

    // The timebase only runs while counting down or playing; it restarts on
    // the way into COUNTDOWN so every game begins on a full second.
    assign tick_en  = (state == PH_COUNTDOWN) || (state == PH_PLAY);
    assign tick_clr = (state == PH_IDLE) && start_rise;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Candidate PLAY counter values: a tick and a life loss in the same cycle
    // both take effect before the GAMEOVER/PAUSE decision is made.
    always_comb begin
        time_next  = time_dec_sat(time_left, tick);
        lives_next = lives_dec_sat(lives, life_lost);
    end

    // Button history for rising-edge detection; a held button fires once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_d <= 1'b0;
            pause_d <= 1'b0;
        end else begin
            start_d <= start;
            pause_d <= pause;
        end
    end

    // Phase sequencer with all game-visible outputs registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PH_IDLE;
            gamestart <= 1'b0;
            countdown <= '0;
            time_left <= TIME_LOAD;
            lives     <= LIVES_LOAD;
            game_over <= 1'b0;
            tick_1s   <= 1'b0;
        end else begin
            tick_1s <= tick;
            case (state)
                PH_IDLE: begin
                    if (start_rise) begin
                        state     <= PH_COUNTDOWN;
                        countdown <= CD_LOAD;
                        time_left <= TIME_LOAD;
                        lives     <= LIVES_LOAD;
                    end
                end

                // The tick that would show 0 hands over to PLAY instead.
                PH_COUNTDOWN: begin
                    if (tick) begin
                        if (countdown <= CD_W'(1)) begin
                            state     <= PH_PLAY;
                            countdown <= '0;
                            gamestart <= 1'b1;
                        end else begin
                            countdown <= countdown - CD_W'(1);
                        end
                    end
                end

                // Running out of time or lives beats a simultaneous pause.
                PH_PLAY: begin
                    time_left <= time_next;
                    lives     <= lives_next;
                    if ((time_next == '0) || (lives_next == '0)) begin
                        state     <= PH_GAMEOVER;
                        gamestart <= 1'b0;
                        game_over <= 1'b1;
                    end else if (pause_rise) begin
                        state     <= PH_PAUSE;
                        gamestart <= 1'b0;
                    end
                end

                // Counters stay frozen; abort to IDLE keeps them as they are
                // until the next start reloads them.
                PH_PAUSE: begin
                    if (pause_rise) begin
                        state     <= PH_PLAY;
                        gamestart <= 1'b1;
                    end else if (start_rise) begin
                        state <= PH_IDLE;
                    end
                end

                PH_GAMEOVER: begin
                    if (start_rise) begin
                        state     <= PH_IDLE;
                        game_over <= 1'b0;
                    end
                end

                // Encodings 5..7 are unreachable; fall back to IDLE.
                default: begin
                    state     <= PH_IDLE;
                    gamestart <= 1'b0;
                    game_over <= 1'b0;
                    countdown <= '0;
                end
            endcase
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_phase_ctrl
// Directed bench for game_phase_ctrl with a short timebase. A behavioural
// model tracks running time in cycles and derives the expected seconds,
// countdown, play timer and lives from it; a compare process checks every
// output on each falling edge, and literal expectations pin key moments.
// ---------------------------------------------------------------------------
module tb_game_phase_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int COUNTDOWN_S = 3;
    localparam int PLAY_TIME_S = 5;
    localparam int LIVES_INIT  = 3;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       start     = 1'b0;
    logic       pause     = 1'b0;
    logic       life_lost = 1'b0;
    logic       gamestart;
    logic [2:0] phase;
    logic [2:0] countdown;
    logic [6:0] time_left;
    logic [1:0] lives;
    logic       game_over;
    logic       tick_1s;

    int checks = 0;
    int errors = 0;

    // Model state: phase number, running cycles since the game was started,
    // lives lost so far, and last-cycle tick / button history.
    int m_phase;
    int m_run;
    int m_losses;
    bit m_tick;
    bit m_sprev;
    bit m_pprev;

    always #5 clk = ~clk;

    game_phase_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .COUNTDOWN_S (COUNTDOWN_S),
        .PLAY_TIME_S (PLAY_TIME_S),
        .LIVES_INIT  (LIVES_INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .life_lost (life_lost),
        .gamestart (gamestart),
        .phase     (phase),
        .countdown (countdown),
        .time_left (time_left),
        .lives     (lives),
        .game_over (game_over),
        .tick_1s   (tick_1s)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit l, input int n);
        start     = s;
        pause     = p;
        life_lost = l;
        repeat (n) @(negedge clk);
    endtask

    // Game rules expressed in elapsed running seconds.
    always @(posedge clk or negedge rst) begin : model
        int nr;
        int nl;
        int tl;
        bit sr;
        bit pr;
        if (!rst) begin
            m_phase  <= 0;
            m_run    <= 0;
            m_losses <= 0;
            m_tick   <= 1'b0;
            m_sprev  <= 1'b0;
            m_pprev  <= 1'b0;
        end else begin
            sr = start && !m_sprev;
            pr = pause && !m_pprev;
            m_sprev <= start;
            m_pprev <= pause;
            m_tick  <= 1'b0;
            case (m_phase)
                0: begin
                    if (sr) begin
                        m_phase  <= 1;
                        m_run    <= 0;
                        m_losses <= 0;
                    end
                end
                1: begin
                    nr = m_run + 1;
                    m_run  <= nr;
                    m_tick <= (nr % TICK_DIV) == 0;
                    if (nr / TICK_DIV >= COUNTDOWN_S) m_phase <= 2;
                end
                2: begin
                    nr = m_run + 1;
                    nl = m_losses + (life_lost ? 1 : 0);
                    tl = PLAY_TIME_S - (nr / TICK_DIV - COUNTDOWN_S);
                    m_run    <= nr;
                    m_losses <= nl;
                    m_tick   <= (nr % TICK_DIV) == 0;
                    if (tl <= 0 || LIVES_INIT - nl <= 0) m_phase <= 4;
                    else if (pr) m_phase <= 3;
                end
                3: begin
                    if (pr) m_phase <= 2;
                    else if (sr) m_phase <= 0;
                end
                default: begin
                    if (sr) m_phase <= 0;
                end
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin : compare
        int secs;
        int exp_cd;
        int exp_time;
        secs     = m_run / TICK_DIV;
        exp_cd   = (m_phase == 1) ? COUNTDOWN_S - secs : 0;
        exp_time = (secs <= COUNTDOWN_S) ? PLAY_TIME_S : PLAY_TIME_S - (secs - COUNTDOWN_S);
        if (exp_time < 0) exp_time = 0;
        checkOutput("phase", phase, m_phase);
        checkOutput("gamestart", gamestart, (m_phase == 2) ? 1 : 0);
        checkOutput("game_over", game_over, (m_phase == 4) ? 1 : 0);
        checkOutput("countdown", countdown, exp_cd);
        checkOutput("time_left", time_left, exp_time);
        checkOutput("lives", lives, LIVES_INIT - m_losses);
        checkOutput("tick_1s", tick_1s, m_tick ? 1 : 0);
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("lit_reset_phase", phase, 0);
        checkOutput("lit_reset_time", time_left, 5);
        checkOutput("lit_reset_lives", lives, 3);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 2);

        // Start held high: enters COUNTDOWN once, never restarts.
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit_entry_phase", phase, 1);
        checkOutput("lit_entry_cd", countdown, 3);
        applyStimulus(1, 0, 0, 3);
        checkOutput("lit_cd_hold", countdown, 3);
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit_cd_step", countdown, 2);
        checkOutput("lit_first_tick", tick_1s, 1);
        applyStimulus(0, 0, 0, 7);
        checkOutput("lit_cd_last", countdown, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit_play_phase", phase, 2);
        checkOutput("lit_play_gs", gamestart, 1);

        // Uninterrupted play runs out of time.
        applyStimulus(0, 0, 0, 19);
        checkOutput("lit_time_one", time_left, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit_timeout_phase", phase, 4);
        checkOutput("lit_timeout_time", time_left, 0);
        checkOutput("lit_timeout_lives", lives, 3);

        // Start in GAMEOVER only returns to IDLE; second press starts.
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit_go_to_idle", phase, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit_restart_phase", phase, 1);

        // Three lives lost during play, start ignored in PLAY.
        applyStimulus(0, 0, 0, 12);
        applyStimulus(0, 0, 1, 1);
        checkOutput("lit_lives_two", lives, 2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("lit_lives_out_phase", phase, 4);
        checkOutput("lit_lives_out_time", time_left, 4);
        applyStimulus(0, 0, 0, 5);
        checkOutput("lit_go_hold_time", time_left, 4);

        // Life loss coincident with the final tick.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 12);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 18);
        checkOutput("lit_coinc_pre_time", time_left, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("lit_coinc_time", time_left, 0);
        checkOutput("lit_coinc_lives", lives, 1);
        checkOutput("lit_coinc_phase", phase, 4);

        // Pause and life loss ignored in COUNTDOWN; pause/resume in PLAY.
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 5);
        applyStimulus(0, 1, 1, 1);
        checkOutput("lit_cd_ignore_phase", phase, 1);
        applyStimulus(0, 0, 0, 6);
        applyStimulus(0, 0, 0, 9);
        checkOutput("lit_pre_pause_time", time_left, 3);
        applyStimulus(0, 1, 0, 1);
        checkOutput("lit_pause_phase", phase, 3);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 48);
        checkOutput("lit_pause_long_phase", phase, 3);
        checkOutput("lit_pause_long_time", time_left, 3);
        applyStimulus(0, 1, 0, 1);
        checkOutput("lit_resume_phase", phase, 2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lit_resume_tick_time", time_left, 2);
        checkOutput("lit_resume_tick", tick_1s, 1);

        // Abort from PAUSE keeps counters until the next start reloads them.
        applyStimulus(0, 1, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit_abort_phase", phase, 0);
        checkOutput("lit_abort_time", time_left, 2);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("lit_reload_time", time_left, 5);
        applyStimulus(0, 0, 0, 5);

        // Asynchronous reset mid-countdown.
        #2 rst = 1'b0;
        #1;
        checkOutput("lit_async_phase", phase, 0);
        checkOutput("lit_async_cd", countdown, 0);
        checkOutput("lit_async_time", time_left, 5);
        checkOutput("lit_async_lives", lives, 3);
        @(negedge clk);
        applyStimulus(0, 0, 0, 2);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
